// File: rtl/bitwise_feeder.sv
// rtl/bitwise_feeder.sv - FIFO-buffered register front end for the combinational bitwise unit
module bitwise_feeder #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_x,
    input  logic [W-1:0]             in_y,
    output logic [W-1:0]             x,
    output logic [W-1:0]             y,
    input  logic [W-1:0]             z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_x,
    output logic [W-1:0]             out_y,
    output logic [W-1:0]             out_z,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  mem_x [DEPTH];
    logic [W-1:0]  mem_y [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          capture;
    logic          release_out;
    logic          fifo_nonempty;

    // in_ready comes from the registered count only, so a same-cycle pop never frees a slot early
    assign in_ready      = (count < FULL_COUNT);
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count != '0);

    // Operand storage; contents are not reset because pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: DRIVE is always exactly one cycle so z settles from registered x/y
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_next = fifo_nonempty ? DRIVE : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: pop loads the unit's operands, capture latches the result, release ends delivery
    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                pop = fifo_nonempty;
            end
            DRIVE: begin
                capture = 1'b1;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    pop         = fifo_nonempty;
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Operand and result registers; out_* only move on capture so they stay stable under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (pop) begin
                x <= mem_x[rd_ptr];
                y <= mem_y[rd_ptr];
            end
            if (capture) begin
                out_x     <= x;
                out_y     <= y;
                out_z     <= z;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_feeder.sv
// tb/tb_bitwise_feeder.sv - scoreboard bench for bitwise_feeder
module tb_bitwise_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_x;
    logic [2:0] in_y;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_x;
    logic [2:0] out_y;
    logic [2:0] out_z;
    logic [2:0] count;

    logic       mode;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    bitwise_feeder #(.W(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .count     (count)
    );

    always #5 clk = ~clk;

    // mode 0: xor stub; mode 1: stand-in for the real unit (nand)
    always_comb begin
        z = mode ? ~(x & y) : (x ^ y);
    end

    function automatic logic [2:0] model_z(input logic [2:0] a, input logic [2:0] b, input logic m);
        return m ? ~(a & b) : (a ^ b);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output monitor: compare each delivered result against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("out_x", out_x, mon_e.x);
                check_val("out_y", out_y, mon_e.y);
                check_val("out_z", out_z, mon_e.z);
            end
        end
    end

    task automatic do_push(input logic [2:0] a, input logic [2:0] b);
        bit done = 0;
        in_valid = 1'b1;
        in_x     = a;
        in_y     = b;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) check_val("push_timeout", 32'd0, 32'd1);
        else sb.push_back('{x: a, y: b, z: model_z(a, b, mode)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check_val(tag, sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_state(input string tag);
        check_val({tag, "_count"}, count, 32'd0);
        check_val({tag, "_in_ready"}, in_ready, 32'd1);
        check_val({tag, "_out_valid"}, out_valid, 32'd0);
        check_val({tag, "_x"}, x, 32'd0);
        check_val({tag, "_y"}, y, 32'd0);
        check_val({tag, "_out_x"}, out_x, 32'd0);
        check_val({tag, "_out_y"}, out_y, 32'd0);
        check_val({tag, "_out_z"}, out_z, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_state("reset");
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single pair: latency and operand order
        do_push(3'd3, 3'd4);
        check_val("single_count1", count, 32'd1);
        @(posedge clk);
        #1;
        check_val("single_x", x, 32'd3);
        check_val("single_y", y, 32'd4);
        check_val("single_count0", count, 32'd0);
        check_val("single_ov_early", out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_val("single_ov", out_valid, 32'd1);
        check_val("single_out_x", out_x, 32'd3);
        check_val("single_out_y", out_y, 32'd4);
        check_val("single_out_z", out_z, 32'd7);
        wait_drain("single_drain");
        check_val("single_ov_clear", out_valid, 32'd0);

        // Burst to full with downstream stalled
        out_ready = 1'b0;
        do_push(3'd7, 3'd5);
        do_push(3'd0, 3'd1);
        do_push(3'd3, 3'd3);
        do_push(3'd1, 3'd2);
        do_push(3'd6, 3'd6);
        check_val("burst_count_full", count, 32'd4);
        check_val("burst_in_ready", in_ready, 32'd0);
        check_val("burst_ov", out_valid, 32'd1);

        // Backpressure: an extra pair is offered but refused, outputs hold
        in_valid = 1'b1;
        in_x     = 3'd2;
        in_y     = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_out_x", out_x, 32'd7);
            check_val("bp_out_y", out_y, 32'd5);
            check_val("bp_out_z", out_z, 32'd2);
            check_val("bp_ov", out_valid, 32'd1);
            check_val("bp_count", count, 32'd4);
            check_val("bp_in_ready", in_ready, 32'd0);
        end
        fork
            do_push(3'd2, 3'd5);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("burst_drain");

        // Mid-cycle reset with 3 queued entries and a pending result
        out_ready = 1'b0;
        do_push(3'd1, 3'd1);
        do_push(3'd2, 3'd2);
        do_push(3'd3, 3'd3);
        do_push(3'd4, 3'd4);
        check_val("pre_rst_count", count, 32'd3);
        check_val("pre_rst_ov", out_valid, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero_state("async_rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("post_rst_ov", out_valid, 32'd0);
        check_val("post_rst_count", count, 32'd0);

        // Simultaneous push and pop at count 2, then a wrapping stream
        out_ready = 1'b0;
        do_push(3'd5, 3'd1);
        do_push(3'd6, 3'd2);
        do_push(3'd7, 3'd3);
        check_val("simul_pre_count", count, 32'd2);
        check_val("simul_pre_ov", out_valid, 32'd1);
        out_ready = 1'b1;
        do_push(3'd4, 3'd6);
        check_val("simul_count", count, 32'd2);
        for (int i = 0; i < 10; i++) begin
            do_push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        wait_drain("stream_drain");

        // Integration with the stand-in bitwise unit
        mode = 1'b1;
        do_push(3'd3, 3'd4);
        do_push(3'd7, 3'd5);
        do_push(3'd0, 3'd1);
        do_push(3'd3, 3'd3);
        wait_drain("integ_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
